// File: rtl/ibm1620_core_pkg.sv
// ============================================================================
// Module      : ibm1620_core_pkg
// Description : Shared types, timing defaults and helpers for the 1620 core
//               memory cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibm1620_core_pkg;

    localparam int DIGIT_W        = 6;
    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_T_ADDR     = 2;
    localparam int DEF_T_READ     = 4;
    localparam int DEF_T_GAP      = 1;
    localparam int DEF_T_WRITE    = 4;
    localparam int DEF_T_RECOV    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_READ   = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_RECOV  = 3'd6
    } core_state_t;

    // A 1620 digit (C,F,8,4,2,1) is valid when its ones count is odd.
    function automatic logic odd_parity_ok(input logic [DIGIT_W-1:0] digit);
        return ^digit;
    endfunction

    // Phase lengths of zero are stretched to one clock.
    function automatic int at_least_one(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibm1620_core_arb.sv
// ============================================================================
// Module      : ibm1620_core_arb
// Description : CPU / IO arbiter for the single core stack. IO has fixed
//               priority; after two consecutive IO grants taken while the CPU
//               was waiting, the CPU wins the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibm1620_core_arb (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic io_req,
    input  logic take,         // a grant is being issued this clock
    output logic winner,       // 1 = IO, 0 = CPU
    output logic grant_valid
);

    // Consecutive IO grants issued while the CPU was kept waiting.
    logic [1:0] io_run;

    // Fixed IO priority unless the CPU has been passed over twice in a row.
    always_comb begin
        grant_valid = cpu_req | io_req;
        winner      = io_req & ~(cpu_req & (io_run == 2'd2));
    end

    // Track IO grants that starved a pending CPU request; any other grant clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_run <= 2'd0;
        end else if (take && grant_valid) begin
            io_run <= (winner && cpu_req) ? io_run + 2'd1 : 2'd0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ibm1620_core_cycle_ctrl.sv
// ============================================================================
// Module      : ibm1620_core_cycle_ctrl
// Description : Sequences one destructive-read / regenerate core cycle per
//               access, arbitrating between CPU and IO requesters.
//               Optional digit parity check: define IBM1620_CORE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibm1620_core_cycle_ctrl
    import ibm1620_core_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int T_ADDR  = DEF_T_ADDR,
    parameter int T_READ  = DEF_T_READ,
    parameter int T_GAP   = DEF_T_GAP,
    parameter int T_WRITE = DEF_T_WRITE,
    parameter int T_RECOV = DEF_T_RECOV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              io_req,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              owner,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [ADDR_W-1:0] core_addr,
    output logic              rd_drive,
    output logic              wr_drive,
    output logic [DATA_W-1:0] inhibit,
    input  logic [DATA_W-1:0] sense,
    output logic              sense_strobe
`ifdef IBM1620_CORE_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int LEN_ADDR  = at_least_one(T_ADDR);
    localparam int LEN_READ  = at_least_one(T_READ);
    localparam int LEN_GAP   = at_least_one(T_GAP);
    localparam int LEN_WRITE = at_least_one(T_WRITE);
    localparam int LEN_RECOV = at_least_one(T_RECOV);
    localparam int LEN_MAX   = imax(imax(imax(LEN_ADDR, LEN_READ), imax(LEN_GAP, LEN_WRITE)), LEN_RECOV);
    localparam int CNT_W     = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

    // The counter holds "clocks remaining after this one" in each phase.
    localparam logic [CNT_W-1:0] LD_ADDR  = CNT_W'(LEN_ADDR  - 1);
    localparam logic [CNT_W-1:0] LD_READ  = CNT_W'(LEN_READ  - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(LEN_GAP   - 1);
    localparam logic [CNT_W-1:0] LD_WRITE = CNT_W'(LEN_WRITE - 1);
    localparam logic [CNT_W-1:0] LD_RECOV = CNT_W'(LEN_RECOV - 1);

    core_state_t       state;
    core_state_t       state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              grant_take;
    logic              winner;
    logic              grant_valid;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;

    ibm1620_core_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .io_req      (io_req),
        .take        (grant_take),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    // State register and phase down-counter; reset abandons any cycle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: count down within a phase, load the next phase length on entry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_take = 1'b0;
        if (state != ST_IDLE && cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_next = ST_ADDR;
                        cnt_next   = LD_ADDR;
                        grant_take = 1'b1;
                    end
                end
                ST_ADDR:   begin state_next = ST_READ;   cnt_next = LD_READ;  end
                ST_READ:   begin state_next = ST_STROBE; cnt_next = '0;       end
                ST_STROBE: begin state_next = ST_GAP;    cnt_next = LD_GAP;   end
                ST_GAP:    begin state_next = ST_WRITE;  cnt_next = LD_WRITE; end
                ST_WRITE:  begin state_next = ST_RECOV;  cnt_next = LD_RECOV; end
                ST_RECOV:  begin state_next = ST_IDLE;   cnt_next = '0;       end
                default:   begin state_next = ST_IDLE;   cnt_next = '0;       end
            endcase
        end
    end

    // Grant pulse, request latching, owner tracking and sense capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_gnt   <= 1'b0;
            io_gnt    <= 1'b0;
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            cpu_gnt <= 1'b0;
            io_gnt  <= 1'b0;
            if (grant_take) begin
                cpu_gnt   <= ~winner;
                io_gnt    <= winner;
                owner     <= winner;
                lat_addr  <= winner ? io_addr  : cpu_addr;
                lat_wr    <= winner ? io_wr    : cpu_wr;
                lat_wdata <= winner ? io_wdata : cpu_wdata;
            end
            if (state == ST_STROBE) begin
                rdata <= sense;
            end
        end
    end

`ifdef IBM1620_CORE_PARITY_EN
    // Flag a bad digit at strobe time; the flag lives until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (grant_take) begin
            parity_err <= 1'b0;
        end else if (state == ST_STROBE) begin
            parity_err <= ~(odd_parity_ok(sense[DIGIT_W-1:0]) &
                            odd_parity_ok(sense[2*DIGIT_W-1:DIGIT_W]));
        end
    end
`endif

    // Drive outputs decoded from the phase; inhibit regenerates sensed data on reads.
    always_comb begin
        rd_drive     = (state == ST_READ);
        sense_strobe = (state == ST_STROBE);
        wr_drive     = (state == ST_WRITE);
        done         = (state == ST_RECOV) && (cnt == '0);
        core_addr    = (state != ST_IDLE) ? lat_addr : '0;
        inhibit      = '0;
        if (state == ST_WRITE) begin
            inhibit = lat_wr ? ~lat_wdata : ~rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibm1620_core_cycle_ctrl.sv
// ============================================================================
// Module      : tb_ibm1620_core_cycle_ctrl
// Description : Directed self-checking bench for ibm1620_core_cycle_ctrl.
//               Parity checks are built when IBM1620_CORE_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibm1620_core_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr, io_req, io_wr;
    logic [13:0] cpu_addr, io_addr;
    logic [11:0] cpu_wdata, io_wdata;
    logic        cpu_gnt, io_gnt, owner, done;
    logic [11:0] rdata, inhibit, sense;
    logic [13:0] core_addr;
    logic        rd_drive, wr_drive, sense_strobe;
`ifdef IBM1620_CORE_PARITY_EN
    logic        parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int tcount = 0;
    int last_done_t = 0;
    logic got;
    logic [5:0] exp_seq;

    ibm1620_core_cycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .io_req       (io_req),
        .io_wr        (io_wr),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_gnt       (io_gnt),
        .owner        (owner),
        .rdata        (rdata),
        .done         (done),
        .core_addr    (core_addr),
        .rd_drive     (rd_drive),
        .wr_drive     (wr_drive),
        .inhibit      (inhibit),
        .sense        (sense),
        .sense_strobe (sense_strobe)
`ifdef IBM1620_CORE_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the grant clock (t0); walks to done at t0+13 and one idle clock.
    task automatic walk_cycle(input logic [13:0] ea, input logic [11:0] einh,
                              input logic [11:0] erd, input logic eown);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                cpu_req = 1'b0;
                io_req  = 1'b0;
            end
            check("rd_drive", rd_drive, (k >= 2 && k <= 5));
            check("sense_strobe", sense_strobe, (k == 6));
            check("wr_drive", wr_drive, (k >= 8 && k <= 11));
            check("inhibit", inhibit, (k >= 8 && k <= 11) ? einh : 12'h000);
            check("done", done, (k == 13));
            check("core_addr", core_addr, ea);
        end
        check("rdata", rdata, erd);
        check("owner", owner, eown);
        tick();
        check("idle_core_addr", core_addr, 14'h0000);
        check("idle_done", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 1'b0;  io_wr = 1'b0;  io_addr = '0;  io_wdata = '0;
        sense = '0;
        exp_seq = 6'b011011;

        // Reset state
        tick(); tick();
        check("rst_rdata", rdata, 12'h000);
        check("rst_core_addr", core_addr, 14'h0000);
        check("rst_inhibit", inhibit, 12'h000);
        check("rst_drives", {rd_drive, wr_drive, sense_strobe, done}, 4'b0000);
        check("rst_gnts", {cpu_gnt, io_gnt, owner}, 3'b000);
        reset = 1'b0;
        tick();
        check("idle_no_gnt", {cpu_gnt, io_gnt}, 2'b00);

        // CPU read, 0x0123, sense 5A3 -> regenerate inhibit A5C
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0123; cpu_wdata = 12'h777;
        sense = 12'h5A3;
        tick();
        check("cpu_gnt", cpu_gnt, 1'b1);
        check("cpu_gnt_io", io_gnt, 1'b0);
        walk_cycle(14'h0123, 12'hA5C, 12'h5A3, 1'b0);

        // IO write 0F1 to 0x1000, sense FFF -> inhibit F0E, old data returned
        io_req = 1'b1; io_wr = 1'b1; io_addr = 14'h1000; io_wdata = 12'h0F1;
        sense = 12'hFFF;
        tick();
        check("io_gnt", io_gnt, 1'b1);
        check("io_gnt_cpu", cpu_gnt, 1'b0);
        walk_cycle(14'h1000, 12'hF0E, 12'hFFF, 1'b1);

        // Both requesters held: IO, IO, CPU, IO, IO, CPU with an idle clock between cycles
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0100;
        io_req  = 1'b1; io_wr  = 1'b0; io_addr  = 14'h0200;
        sense = 12'h3C3;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                tick();
                if (done) last_done_t = tcount;
                if (cpu_gnt || io_gnt) got = 1'b1;
            end
            check("grant_seen", cpu_gnt | io_gnt, 1'b1);
            check("grant_order", io_gnt, exp_seq[g]);
            check("grant_onehot", cpu_gnt ^ io_gnt, 1'b1);
            if (g > 0) check("idle_gap", (tcount - last_done_t) >= 2, 1'b1);
        end
        cpu_req = 1'b0; io_req = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            tick();
            if (done) got = 1'b1;
        end
        check("drain_done", done, 1'b1);
        check("drain_owner", owner, 1'b0);
        tick();

        // Reset during the second READ clock, with the CPU request still pending
        cpu_req = 1'b1; cpu_addr = 14'h0456;
        tick();
        check("pre_rst_gnt", cpu_gnt, 1'b1);
        tick(); tick(); tick();
        check("pre_rst_rd", rd_drive, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rd_drive", rd_drive, 1'b0);
        check("async_core_addr", core_addr, 14'h0000);
        check("async_rdata", rdata, 12'h000);
        check("async_misc", {wr_drive, sense_strobe, done, cpu_gnt, io_gnt, owner}, 6'b000000);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("post_rst_gnt", cpu_gnt, 1'b1);
        check("post_rst_addr", core_addr, 14'h0456);
        cpu_req = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            tick();
            if (done) got = 1'b1;
        end
        check("post_rst_done", done, 1'b1);
        check("post_rst_rdata", rdata, 12'h3C3);
        tick();

`ifdef IBM1620_CORE_PARITY_EN
        // Low digit even parity -> flag after strobe, held, cleared at next grant
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0042;
        sense = 12'b000001_000011;
        tick();
        check("par_clear_gnt0", parity_err, 1'b0);
        walk_cycle(14'h0042, 12'b111110_111100, 12'b000001_000011, 1'b0);
        check("par_err_held", parity_err, 1'b1);
        cpu_req = 1'b1;
        sense = 12'b000001_000001;
        tick();
        check("par_clear_gnt", parity_err, 1'b0);
        walk_cycle(14'h0042, 12'b111110_111110, 12'b000001_000001, 1'b0);
        check("par_ok", parity_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibm1620_core_cycle_ctrl.md
Name: ibm1620_core_cycle_ctrl

Overview:
- Sequences one destructive-read / regenerate core-memory cycle per access for the 1620 core stack.
- Drives the SMS core driver and inhibit cards, strobes the sense amplifiers, and latches read data.
- Arbitrates the single core stack between the CPU and the I/O channel.
- Sits between the CPU/IO address-data registers and the core driver, sense and inhibit card models.

Parameters:
- ADDR_W, 14, digit-pair address width (20000 digits, 2 digits per access).
- DATA_W, 12, two 6-bit digits (C,F,8,4,2,1 each).
- T_ADDR, 2, clocks for address settle before read drive.
- T_READ, 4, clocks of read (half-select) drive.
- T_GAP, 1, clocks between strobe and write drive.
- T_WRITE, 4, clocks of write drive with inhibit.
- T_RECOV, 2, recovery clocks before the next cycle.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_wr  in  1  1=write, 0=read (regenerate).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-clock grant pulse.
- io_req, io_wr, io_addr, io_wdata, io_gnt  same as the cpu_* ports, for the I/O channel.
- owner  out  1  requester of the current or last cycle (1=IO).
- rdata  out  DATA_W  data sensed in the last cycle.
- done  out  1  one-clock pulse at cycle end; rdata valid from this clock on.
- core_addr  out  ADDR_W  address to the X/Y drivers.
- rd_drive  out  1  read drive enable.
- wr_drive  out  1  write drive enable.
- inhibit  out  DATA_W  per-bit inhibit during wr_drive.
- sense  in  DATA_W  sense amplifier outputs.
- sense_strobe  out  1  sense sample pulse.
- parity_err  out  1  present only with the optional feature.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0, including rdata, core_addr and inhibit. Any cycle in progress is abandoned mid-cycle: drives drop immediately and no regenerate occurs, so that word's core contents are lost by design.
- States: IDLE -> ADDR(T_ADDR) -> READ(T_READ) -> STROBE(1) -> GAP(T_GAP) -> WRITE(T_WRITE) -> RECOV(T_RECOV) -> IDLE.
- A single down-counter loads each phase length on entry. The default full cycle is 14 clocks, from the gnt clock to the done clock inclusive.
- IDLE: on any req, pick a winner, pulse its gnt for 1 clock, latch addr/wr/wdata into internal registers, and enter ADDR.
- core_addr is held from the gnt clock until the end of RECOV.
- rd_drive=1 only in READ; sense_strobe=1 only in STROBE. At the STROBE clock edge, sense is latched into the internal data register.
- WRITE: wr_drive=1.
  - Read cycle: inhibit = ~latched sense (regenerate).
  - Write cycle: inhibit = ~latched wdata.
  - inhibit=0 outside WRITE.
- rdata updates at the STROBE edge with sensed data for both read and write cycles, so writes return the old contents.
- done pulses on the last RECOV clock; owner holds its value until the next grant.
- Arbitration: io_req beats cpu_req. Starvation guard: after 2 consecutive IO grants while cpu_req was pending, the next grant goes to the CPU. The counter clears on any CPU grant.
- A req deasserted after gnt is ignored and the cycle completes. A req reasserted during a cycle is serviced at IDLE.
- Back-to-back: done and the next gnt never share a clock; IDLE lasts at least 1 clock.
- Any parameter value of 0 is treated as 1.

Optional Feature:
- Macro IBM1620_CORE_PARITY_EN.
- Defined: at the STROBE edge, each 6-bit digit of sense is checked for odd parity. parity_err is set if either digit has even parity, and is held until the next gnt or reset. The cycle still regenerates the data unchanged.
- Undefined: parity_err port and logic are absent.

Decomposition:
- Package ibm1620_core_pkg holds:
  - the state enum;
  - default timing constants;
  - DIGIT_W=6;
  - a function odd_parity_ok(digit).
- One sub-module, ibm1620_core_arb: the two-requester fixed priority with starvation counter. It outputs winner and grant_valid.

Test Plan:
- CPU read of addr 0x0123 with sense=12'h5A3 -> cpu_gnt at t0, rd_drive for 4 clocks, strobe at t0+6, inhibit=12'hA5C during the 4 WRITE clocks, done at t0+13, rdata=12'h5A3.
- IO write of 12'h0F1 to 0x1000 with sense=12'hFFF -> inhibit=12'hF0E in WRITE, rdata=12'hFFF, owner=1.
- cpu_req and io_req both held continuously -> grant order IO, IO, CPU, IO, IO, CPU.
- reset asserted in READ (2nd clock) -> rd_drive and all outputs 0 asynchronously; after release, IDLE, and a pending cpu_req is granted on the first clock.
- cpu_req dropped 1 clock after gnt -> full 14-clock cycle with done. Back-to-back requests -> at least 1 idle clock between done and the next gnt.
- Parity enabled, sense=12'b000001_000011 (low digit even) -> parity_err=1 after strobe, cleared at the next gnt.
